// File: rtl/ic_fill_pkg.sv
// Shared types and geometry for the I-cache line-fill controller.
// Line address slicing lives here so the set/tag split is defined once.
package ic_fill_pkg;

   localparam int ADDR_W          = 32;
   localparam int BLOCK_WORDS     = 16;
   localparam int WORDS_PER_CYCLE = 2;
   localparam int BEATS           = BLOCK_WORDS / WORDS_PER_CYCLE;
   localparam int BEAT_W          = $clog2(BEATS);
   localparam int LINE_OFF_W      = 6;
   localparam int WORD_OFF_W      = $clog2(BLOCK_WORDS);
   localparam int NUM_SETS        = 32;
   localparam int SET_W           = $clog2(NUM_SETS);
   localparam int LINE_ADDR_W     = ADDR_W - LINE_OFF_W;
   localparam int TAG_W           = LINE_ADDR_W - SET_W;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      FILL,
      DONE
   } ic_fill_state_t;

   typedef struct packed {
      logic [TAG_W-1:0] tag;
      logic [SET_W-1:0] set;
   } line_fields_t;

   function automatic line_fields_t slice_line(input logic [LINE_ADDR_W-1:0] line_addr);
      line_fields_t f;
      f.set = line_addr[SET_W-1:0];
      f.tag = line_addr[LINE_ADDR_W-1 -: TAG_W];
      return f;
   endfunction

endpackage

// File: rtl/ic_fill_ctrl.sv
// I-cache line-fill initiator: requests a line from main memory on a miss,
// writes each returned beat into the arrays and flags the early-restart word.
module ic_fill_ctrl
   import ic_fill_pkg::*;
(
   input  logic                   clk_i,
   input  logic                   reset_i,
   input  logic                   miss_valid_i,
   input  logic [ADDR_W-1:0]      miss_addr_i,
   output logic                   ic_repl_permit_o,
   output logic                   cache_hit_o,
   input  logic                   rep_ready_i,
   input  logic [63:0]            rep_word_i,
   output logic                   fill_we_o,
   output logic [SET_W-1:0]       fill_set_o,
   output logic [TAG_W-1:0]       fill_tag_o,
   output logic [BEAT_W-1:0]      fill_beat_o,
   output logic [63:0]            fill_data_o,
   output logic                   crit_valid_o,
   output logic [31:0]            crit_word_o,
   output logic                   fill_done_o,
   output logic                   busy_o
);

   ic_fill_state_t          r_state;
   logic [BEAT_W-1:0]       r_beat_cnt;
   logic [LINE_ADDR_W-1:0]  r_line;
   logic [WORD_OFF_W-1:0]   r_word_off;

   ic_fill_state_t          w_next_state;
   logic [BEAT_W-1:0]       w_next_beat;
   logic                    w_accept;
   logic                    w_permit;
   logic                    w_busy;
   logic                    w_we;
   logic                    w_hit;
   logic                    w_live;
   logic                    w_held;
   logic                    w_crit;
   line_fields_t            w_line;
   logic                    w_unused_addr;

   // Byte-offset bits never reach the arrays; instruction fetch is word aligned.
   assign w_unused_addr = ^miss_addr_i[1:0];

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of the others, independent of block ordering.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_state    <= IDLE;
         r_beat_cnt <= '0;
         r_line     <= '0;
         r_word_off <= '0;
      end else begin
         r_state    <= w_next_state;
         r_beat_cnt <= w_next_beat;
         if (w_accept) begin
            r_line     <= miss_addr_i[ADDR_W-1:LINE_OFF_W];
            r_word_off <= miss_addr_i[LINE_OFF_W-1:2];
         end
      end
   end

   // NOTE: every signal written here gets a default first, so no path through
   // the case statement can leave one unassigned and infer a latch.
   always_comb begin
      w_next_state = r_state;
      w_next_beat  = r_beat_cnt;
      w_accept     = 1'b0;
      w_permit     = 1'b0;
      w_busy       = 1'b0;
      w_we         = 1'b0;
      w_hit        = 1'b0;
      unique case (r_state)
         IDLE: begin
            w_next_beat = '0;
            if (miss_valid_i) begin
               w_accept     = 1'b1;
               w_busy       = 1'b1;
               w_next_state = REQ;
            end
         end
         REQ: begin
            w_permit = 1'b1;
            w_busy   = 1'b1;
            if (rep_ready_i) begin
               w_we         = 1'b1;
               w_next_beat  = BEAT_W'(1);
               w_next_state = FILL;
            end
         end
         FILL: begin
            w_busy = 1'b1;
            if (rep_ready_i) begin
               w_we = 1'b1;
               if (r_beat_cnt == BEAT_W'(BEATS - 1)) begin
                  w_next_beat  = '0;
                  w_next_state = DONE;
               end else begin
                  w_next_beat = r_beat_cnt + 1'b1;
               end
            end else begin
               // Memory broke the stream: discard the partial line and re-request.
               w_next_beat  = '0;
               w_next_state = REQ;
            end
         end
         DONE: begin
            w_busy       = 1'b1;
            w_hit        = 1'b1;
            w_next_state = IDLE;
         end
         default: begin
            w_next_beat  = '0;
            w_next_state = IDLE;
         end
      endcase
   end

   assign w_live = ~reset_i;
   assign w_held = w_live && (r_state != IDLE);
   assign w_line = slice_line(r_line);
   assign w_crit = w_we && (r_beat_cnt == r_word_off[WORD_OFF_W-1:1]);

   assign busy_o           = w_live & w_busy;
   assign ic_repl_permit_o = w_live & w_permit;
   assign cache_hit_o      = w_live & w_hit;
   assign fill_done_o      = w_live & w_hit;
   assign fill_we_o        = w_live & w_we;
   assign fill_beat_o      = (w_live && w_we) ? r_beat_cnt : '0;
   assign fill_data_o      = (w_live && w_we) ? rep_word_i : '0;
   assign fill_set_o       = w_held ? w_line.set : '0;
   assign fill_tag_o       = w_held ? w_line.tag : '0;
   assign crit_valid_o     = w_live & w_crit;
   assign crit_word_o      = (w_live && w_crit)
                             ? (r_word_off[0] ? rep_word_i[63:32] : rep_word_i[31:0])
                             : '0;

endmodule

// File: doc/ic_fill_ctrl.md
Name: ic_fill_ctrl

Overview:
Instruction-cache line-fill initiator. It is the cache-side end of the main-memory replacement interface. On an I-cache miss it raises the replacement permit and captures the 64-bit beats that main memory streams back. Each beat is written into the cache data/tag arrays as it arrives, and an early-restart critical word is flagged. Once the line is complete, the block signals completion back to memory so that memory returns to idle.

Parameters:
ADDR_W, 32, address width
BLOCK_WORDS, 16, 32-bit words per cache line (64 B)
WORDS_PER_CYCLE, 2, words per memory beat; BEATS = BLOCK_WORDS/WORDS_PER_CYCLE = 8
NUM_SETS, 32, cache sets; SET_W = log2(NUM_SETS) = 5; TAG_W = ADDR_W-6-SET_W = 21

Ports:
clk_i  in  1  clock
reset_i  in  1  synchronous active-high reset
miss_valid_i  in  1  cache lookup missed this cycle
miss_addr_i  in  ADDR_W  fetch address of the miss
ic_repl_permit_o  out  1  replacement request to main memory
cache_hit_o  out  1  line complete; tells memory to end the transfer
rep_ready_i  in  1  memory streaming beats
rep_word_i  in  64  current beat: [31:0] = even word, [63:32] = odd word
fill_we_o  out  1  write current beat into data array
fill_set_o  out  SET_W  set index of the line being filled
fill_tag_o  out  TAG_W  tag to install
fill_beat_o  out  3  beat index (word offset / 2)
fill_data_o  out  64  beat data
crit_valid_o  out  1  requested word available this cycle
crit_word_o  out  32  requested word
fill_done_o  out  1  one-cycle pulse: line valid, set valid bit
busy_o  out  1  fill in progress; pipeline fetch stall

Behaviour:
- Clock and reset:
  - One clock, clk_i. reset_i is synchronous and active-high.
  - Reset forces state IDLE and clears beat_cnt and the latched address.
  - While reset or idle, all outputs are 0.
  - Reset mid-fill aborts without setting fill_done_o. Memory shares the same reset.
- State machine, ic_fill_state_t: IDLE, REQ, FILL, DONE.
- IDLE:
  - miss_valid_i=1 latches the line address miss_addr_i[31:6] and the offset bits [5:2].
  - Next state REQ.
  - busy_o is asserted combinationally in the same cycle as miss_valid_i.
- REQ:
  - ic_repl_permit_o=1 and busy_o=1.
  - Memory asserts rep_ready_i one cycle after it samples the permit, with beat 0 valid.
  - When rep_ready_i=1: capture beat 0 (fill_we_o=1, fill_beat_o=0), set beat_cnt=1, next state FILL.
- FILL:
  - Memory advances one beat per cycle, with no backpressure.
  - Each cycle with rep_ready_i=1: fill_we_o=1, fill_beat_o=beat_cnt, beat_cnt+1.
  - After capturing beat BEATS-1, next state DONE.
  - If rep_ready_i drops mid-fill (protocol error), beat_cnt clears, next state REQ, and the fill restarts from beat 0. fill_done_o is never raised for a partial line.
- DONE:
  - cache_hit_o=1 and fill_done_o=1 for exactly one cycle; next state IDLE.
  - Memory samples cache_hit_o and drops rep_ready_i on the next cycle.
  - No permit is raised in DONE, which guarantees memory is back in NO_REQ before any new request.
- Write-port outputs:
  - fill_set_o = latched addr[10:6]; fill_tag_o = latched addr[31:11]. Both are held stable from REQ through DONE.
  - fill_we_o, fill_beat_o and fill_data_o are combinational from state, rep_ready_i and beat_cnt.
  - fill_data_o = rep_word_i; the array write occurs at the clock edge.
- Critical word:
  - crit_valid_o=1 in the beat-capture cycle where the captured beat index == latched addr[5:3].
  - crit_word_o = addr[2] ? rep_word_i[63:32] : rep_word_i[31:0].
- Other rules:
  - miss_valid_i is ignored outside IDLE.
  - beat_cnt is 3 bits and never wraps in normal operation, because it terminates at 7.
- Latency:
  - Miss at cycle 0 → permit in cycle 1 → beats in cycles 2..9 → DONE in cycle 10 → IDLE in cycle 11.
  - This gives 11 cycles of busy_o.

Decomposition:
- Package ic_fill_pkg holds:
  - ic_fill_state_t enum;
  - BLOCK_WORDS, WORDS_PER_CYCLE, BEATS, LINE_OFF_W=6;
  - a set/tag slicing function.
- No sub-module; the FSM, beat counter and critical-word mux are a single module.

Test Plan:
1. Memory image word n = 0xA000_0000+n; miss at 0x0000_0148 → permit cycle 1; writes in cycles 2..9 to set 5, tag 0, beats 0..7; beat 0 data = {0xA000_0051, 0xA000_0050}; cache_hit_o and fill_done_o high in cycle 10 only.
2. Same miss → crit_valid_o high only in cycle 3 (beat 1), crit_word_o = 0xA000_0052; miss at 0x0000_017C → crit in beat 7, crit_word_o = 0xA000_005F.
3. Back-to-back misses, with the second at 0x0000_0800 asserted in the DONE cycle → ignored; re-asserted in IDLE → permit one cycle later; memory returns beat 0 = words 512/513 with no stale beats.
4. Memory forces rep_ready_i low after beat 3 → no fill_done_o; restart sees fill_beat_o = 0 again, then a full 8-beat fill and one fill_done_o pulse.
5. reset_i pulsed at beat 5 → all outputs 0 in the next cycle, state IDLE; a new miss at 0x0000_0040 completes normally to set 1.
6. miss_valid_i held high continuously through a fill → exactly one fill per request, no re-entry until IDLE, busy_o contiguous.
